// File: rtl/sync_fifo_top.sv
// rtl/sync_fifo_top.sv - single-clock FIFO with level thresholds, sticky error flags and optional FWFT read
module sync_fifo_top #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [DWIDTH-1:0] wrdata,
    output logic              full,
    output logic              almost_full,
    input  logic              pop,
    output logic [DWIDTH-1:0] rddata,
    output logic              empty,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C   = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] AFULL_C   = AFULL_TH[AWIDTH:0];
    localparam logic [AWIDTH:0] AEMPTY_C  = AEMPTY_TH[AWIDTH:0];

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   wrptr;
    logic [AWIDTH:0]   rdptr;
    logic [AWIDTH:0]   count_nxt;
    logic              push_ok;
    logic              pop_ok;

    // Accept decisions use only the registered flags, so no input reaches an output combinationally.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wrptr        <= '0;
            rdptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            if (push_ok) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop_ok) begin
                rdptr <= rdptr + 1'b1;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
        end
    end

    // A new error in the same cycle as clr_err wins, so no event is lost.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wrptr[AWIDTH-1:0]] <= wrdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rddata = mem[rdptr[AWIDTH-1:0]];
        end else begin : g_reg
            logic [DWIDTH-1:0] rddata_q;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    rddata_q <= '0;
                end else if (pop_ok) begin
                    rddata_q <= mem[rdptr[AWIDTH-1:0]];
                end
            end

            assign rddata = rddata_q;
        end
    endgenerate

endmodule
